// File: rtl/exp_req_sched_pkg.sv
// Shared definitions for the exponent request scheduler.
//  - Q4.11 operand width DW and datapath result width RW
//  - EXP_INT_MAX: largest integer part the exponent integer selector can map
//  - tag_t: requester index carried alongside each issued operand
//  - in_range(): range test applied to a granted operand before issue
package exp_pkg;

  localparam int DW      = 15;
  localparam int RW      = 16;
  localparam int INT_LSB = 11;

  localparam logic [3:0] EXP_INT_MAX = 4'd13;

  typedef logic [1:0] tag_t;

  // Integer part is the top four bits of the Q4.11 operand.
  function automatic logic in_range(input logic [DW-1:0] op);
    return op[DW-1:INT_LSB] <= EXP_INT_MAX;
  endfunction

endpackage

// File: rtl/exp_req_sched_if.sv
// Bundle of every handshake/bus signal around the scheduler.
//  slave  : the scheduler's view (requests and datapath results in,
//           grants, issues and responses out)
//  master : the surrounding environment (clients plus shared datapath)
// Signals:
//  req_valid/req_data/req_ready      client operand handshake
//  dp_valid/dp_data/dp_tag           issue towards the shared datapath
//  dp_rvalid/dp_rdata/dp_rtag        tagged datapath results
//  rsp_valid/rsp_data/rsp_err/rsp_ready  per-client response slots
//  drop_err                          sticky orphan-result flag
interface exp_req_sched_if
  import exp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = exp_pkg::DW,
  parameter int RW   = exp_pkg::RW,
  parameter int TW   = $bits(exp_pkg::tag_t)
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  logic               dp_valid;
  logic [DW-1:0]      dp_data;
  logic [TW-1:0]      dp_tag;

  logic               dp_rvalid;
  logic [RW-1:0]      dp_rdata;
  logic [TW-1:0]      dp_rtag;

  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ*RW-1:0] rsp_data;
  logic [NREQ-1:0]    rsp_err;
  logic [NREQ-1:0]    rsp_ready;

  logic               drop_err;

  modport slave (
    input  req_valid, req_data, dp_rvalid, dp_rdata, dp_rtag, rsp_ready,
    output req_ready, dp_valid, dp_data, dp_tag, rsp_valid, rsp_data,
           rsp_err, drop_err
  );

  modport master (
    output req_valid, req_data, dp_rvalid, dp_rdata, dp_rtag, rsp_ready,
    input  req_ready, dp_valid, dp_data, dp_tag, rsp_valid, rsp_data,
           rsp_err, drop_err
  );

endinterface

// File: rtl/exp_req_sched_rr_arbiter.sv
// Round-robin arbiter (purely combinational).
// Grants the first eligible requester at or after ptr, wrapping past NREQ-1.
// Ports:
//  eligible   in   NREQ  requesters that may be granted this cycle
//  ptr        in   TW    highest-priority index (always < NREQ)
//  grant      out  NREQ  one-hot grant (all zero if nothing eligible)
//  grant_idx  out  TW    index of the granted requester
//  any_grant  out  1     a grant was made
module rr_arbiter
  import exp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TW   = $bits(exp_pkg::tag_t)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [TW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [TW-1:0]   grant_idx,
  output logic            any_grant
);

  // Outer loop walks priority order (distance s from ptr); inner loop
  // matches that position to a constant index so every select is static.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int s = 0; s < NREQ; s++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any_grant && eligible[j] &&
            ((int'(ptr) + s == j) || (int'(ptr) + s - NREQ == j))) begin
          grant[j]  = 1'b1;
          grant_idx = TW'(j);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exp_req_sched.sv
// Scheduler sharing one fixed-latency exponent datapath among NREQ clients.
// A round-robin grant accepts one operand per cycle; operands whose integer
// part exceeds EXP_INT_MAX are answered locally with an error response,
// the rest are issued with their requester index as tag. Tagged results
// are routed back into per-requester response slots.
// Ports:
//  clk  in  1  rising-edge clock
//  rst  in  1  asynchronous reset, active-high
//  bus  exp_req_sched_if.slave  request, issue, result and response signals
module exp_req_sched
  import exp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = exp_pkg::DW,
  parameter int RW   = exp_pkg::RW,
  parameter int TW   = $bits(exp_pkg::tag_t)
) (
  input  logic             clk,
  input  logic             rst,
  exp_req_sched_if.slave   bus
);

  logic [NREQ-1:0] busy_reg;
  logic [NREQ-1:0] rsp_valid_reg;
  logic [NREQ-1:0] rsp_err_reg;
  logic [RW-1:0]   rsp_data_reg [NREQ];
  logic [TW-1:0]   ptr_reg;
  logic            dp_valid_reg;
  logic [DW-1:0]   dp_data_reg;
  logic [TW-1:0]   dp_tag_reg;
  logic            drop_err_reg;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [TW-1:0]   grant_idx;
  logic            any_grant;
  logic [DW-1:0]   grant_data;
  logic            grant_ok;
  logic [NREQ-1:0] ret_hit;

  // Eligibility uses start-of-cycle state only, so a slot freed this cycle
  // becomes grantable next cycle. Reset forces every output, including the
  // combinational grant, to zero.
  assign eligible = rst ? '0 : (bus.req_valid & ~busy_reg & ~rsp_valid_reg);

  rr_arbiter #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.req_ready = grant;

  // One-hot mux of the granted operand.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) grant_data = bus.req_data[k*DW +: DW];
    end
  end

  assign grant_ok = in_range(grant_data);

  // A result is accepted only for a requester with an op outstanding.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign ret_hit[gi] = bus.dp_rvalid && (bus.dp_rtag == TW'(gi)) && busy_reg[gi];
    assign bus.rsp_data[gi*RW +: RW] = rsp_data_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg      <= '0;
      rsp_valid_reg <= '0;
      rsp_err_reg   <= '0;
      for (int k = 0; k < NREQ; k++) rsp_data_reg[k] <= '0;
      ptr_reg       <= '0;
      dp_valid_reg  <= 1'b0;
      dp_data_reg   <= '0;
      dp_tag_reg    <= '0;
      drop_err_reg  <= 1'b0;
    end else begin
      // A rejected operand still consumes its round-robin turn.
      if (any_grant) begin
        ptr_reg <= (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end

      dp_valid_reg <= any_grant && grant_ok;
      if (any_grant && grant_ok) begin
        dp_data_reg <= grant_data;
        dp_tag_reg  <= grant_idx;
      end

      if (bus.dp_rvalid && (ret_hit == '0)) drop_err_reg <= 1'b1;

      // Return, reject and release never target the same slot together:
      // a return needs busy, a grant needs !busy & !full, release needs full.
      for (int k = 0; k < NREQ; k++) begin
        if (ret_hit[k]) begin
          busy_reg[k]      <= 1'b0;
          rsp_valid_reg[k] <= 1'b1;
          rsp_err_reg[k]   <= 1'b0;
          rsp_data_reg[k]  <= bus.dp_rdata;
        end else if (grant[k] && !grant_ok) begin
          rsp_valid_reg[k] <= 1'b1;
          rsp_err_reg[k]   <= 1'b1;
          rsp_data_reg[k]  <= '0;
        end else begin
          if (grant[k]) busy_reg[k] <= 1'b1;
          if (rsp_valid_reg[k] && bus.rsp_ready[k]) begin
            rsp_valid_reg[k] <= 1'b0;
            rsp_err_reg[k]   <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.dp_valid  = dp_valid_reg;
  assign bus.dp_data   = dp_data_reg;
  assign bus.dp_tag    = dp_tag_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.drop_err  = drop_err_reg;

endmodule

// File: tb/tb_exp_req_sched.sv
// Scoreboard bench for exp_req_sched: stimulus pushes expected issues and
// responses, monitors pop and compare when the DUT presents them. A small
// fixed-latency datapath model echoes tags LAT cycles after each issue.
module tb_exp_req_sched;
  import exp_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exp_req_sched_if #(.NREQ(NREQ), .DW(DW), .RW(RW), .TW(2)) bus ();

  exp_req_sched #(.NREQ(NREQ), .DW(DW), .RW(RW), .TW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [1:0] tag; logic [DW-1:0] data; } iss_t;
  typedef struct { logic err; logic [RW-1:0] data; } rsp_t;

  iss_t          exp_iss [$];
  rsp_t          exp_rsp [NREQ][$];
  logic [DW-1:0] op_q    [NREQ][$];
  logic [DW-1:0] req_op  [NREQ];
  logic          hold = 1'b1;
  logic [NREQ-1:0] acc = '0;
  logic [NREQ-1:0] prev_rsp = '0;
  int            n_issue = 0;
  logic          inj_pending = 1'b0;
  logic [1:0]    inj_tag = '0;

  logic          pv [LAT+1];
  logic [1:0]    pt [LAT+1];
  logic [DW-1:0] pd [LAT+1];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign bus.req_data[gi*DW +: DW] = req_op[gi];
  end

  // Stand-in exponent datapath result.
  function automatic logic [RW-1:0] dp_fn(input logic [DW-1:0] d);
    return {1'b0, d} ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_iss(input logic [1:0] t, input logic [DW-1:0] d);
    iss_t e;
    e.tag = t; e.data = d;
    exp_iss.push_back(e);
  endtask

  task automatic push_rsp(input int k, input logic err, input logic [RW-1:0] d);
    rsp_t e;
    e.err = err; e.data = d;
    exp_rsp[k].push_back(e);
  endtask

  function automatic logic idle();
    logic r;
    r = (exp_iss.size() == 0) && (bus.req_valid == '0);
    for (int k = 0; k < NREQ; k++) begin
      if (exp_rsp[k].size() != 0 || op_q[k].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = idle();
    end
    check({name, " drained"}, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    hold = 1'b1;
    for (int k = 0; k < NREQ; k++) op_q[k].delete();
    bus.req_valid = '0;
    repeat (LAT + 3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Datapath model: result returns exactly LAT cycles after dp_valid.
  initial begin
    for (int i = 0; i <= LAT; i++) begin pv[i] = 1'b0; pt[i] = '0; pd[i] = '0; end
    bus.dp_rvalid = 1'b0; bus.dp_rtag = '0; bus.dp_rdata = '0;
    forever begin
      @(negedge clk);
      for (int i = LAT; i > 0; i--) begin pv[i] = pv[i-1]; pt[i] = pt[i-1]; pd[i] = pd[i-1]; end
      pv[0] = bus.dp_valid; pt[0] = bus.dp_tag; pd[0] = bus.dp_data;
      if (inj_pending) begin
        bus.dp_rvalid = 1'b1; bus.dp_rtag = inj_tag; bus.dp_rdata = 16'hDEAD;
        inj_pending = 1'b0;
      end else begin
        bus.dp_rvalid = pv[LAT]; bus.dp_rtag = pt[LAT]; bus.dp_rdata = dp_fn(pd[LAT]);
      end
    end
  end

  // Requester feeder: holds each operand until accepted, then loads the next.
  initial begin
    for (int k = 0; k < NREQ; k++) req_op[k] = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid[k] && acc[k]) bus.req_valid[k] = 1'b0;
        if (!hold && !bus.req_valid[k] && op_q[k].size() > 0) begin
          req_op[k] = op_q[k].pop_front();
          bus.req_valid[k] = 1'b1;
        end
      end
    end
  end

  // Monitor: grants, issues and newly filled response slots.
  initial begin
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (bus.dp_valid) begin
        n_issue++;
        $display("issue tag=%0d data=%h", bus.dp_tag, bus.dp_data);
        if (exp_iss.size() == 0) begin
          check("unexpected issue", 64'(bus.dp_tag), 64'hFF);
        end else begin
          iss_t e;
          e = exp_iss.pop_front();
          check("issue tag", 64'(bus.dp_tag), 64'(e.tag));
          check("issue data", 64'(bus.dp_data), 64'(e.data));
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (bus.rsp_valid[k] && !prev_rsp[k]) begin
          $display("rsp k=%0d err=%0b data=%h", k, bus.rsp_err[k], bus.rsp_data[k*RW +: RW]);
          if (exp_rsp[k].size() == 0) begin
            check("unexpected rsp", 64'(k), 64'hFF);
          end else begin
            rsp_t e;
            e = exp_rsp[k].pop_front();
            check("rsp err", 64'(bus.rsp_err[k]), 64'(e.err));
            check("rsp data", 64'(bus.rsp_data[k*RW +: RW]), 64'(e.data));
          end
        end
      end
      prev_rsp = bus.rsp_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    #12;
    // Reset state: everything zero, grants suppressed even with valid high.
    check("rst req_ready", 64'(bus.req_ready), 64'd0);
    check("rst dp_valid",  64'(bus.dp_valid), 64'd0);
    check("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst rsp_data",  64'(bus.rsp_data), 64'd0);
    check("rst drop_err",  64'(bus.drop_err), 64'd0);
    bus.req_valid = '0;
    do_reset();

    // 1: single request, grant in the same cycle, normal return.
    push_iss(2, 15'h0800); push_rsp(2, 1'b0, dp_fn(15'h0800));
    op_q[2].push_back(15'h0800);
    hold = 1'b0;
    @(negedge clk);
    check("t1 req_ready", 64'(bus.req_ready), 64'b0100);
    wait_idle("t1");

    // 2: all four busy; round robin 0,1,2,3,0,1,2,3.
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      op_q[k].push_back(DW'(16'h0100 * k + 1));
      op_q[k].push_back(DW'(16'h0100 * k + 16'h10));
    end
    for (int k = 0; k < NREQ; k++) begin
      push_iss(2'(k), DW'(16'h0100 * k + 1));
      push_rsp(k, 1'b0, dp_fn(DW'(16'h0100 * k + 1)));
    end
    for (int k = 0; k < NREQ; k++) begin
      push_iss(2'(k), DW'(16'h0100 * k + 16'h10));
      push_rsp(k, 1'b0, dp_fn(DW'(16'h0100 * k + 16'h10)));
    end
    hold = 1'b0;
    wait_idle("t2");

    // 3: int=14 rejected without issue; pointer then sits at 2, so the next
    //    burst is served 2 (int=13 edge, issued), 3 (int=15, rejected), 0, 1.
    do_reset();
    n0 = n_issue;
    op_q[1].push_back(15'h7000);
    push_rsp(1, 1'b1, 16'h0000);
    hold = 1'b0;
    wait_idle("t3a");
    check("t3 no issue", 64'(n_issue - n0), 64'd0);
    hold = 1'b1;
    op_q[2].push_back(15'h6FFF); op_q[3].push_back(15'h7FFF);
    op_q[0].push_back(15'h0000); op_q[1].push_back(15'h0001);
    push_iss(2, 15'h6FFF); push_iss(0, 15'h0000); push_iss(1, 15'h0001);
    push_rsp(2, 1'b0, dp_fn(15'h6FFF)); push_rsp(3, 1'b1, 16'h0000);
    push_rsp(0, 1'b0, dp_fn(15'h0000)); push_rsp(1, 1'b0, dp_fn(15'h0001));
    hold = 1'b0;
    wait_idle("t3b");

    // 4: undrained slot 0 blocks requester 0 while 1 keeps being served.
    do_reset();
    bus.rsp_ready = 4'b1110;
    op_q[0].push_back(15'h0123); op_q[0].push_back(15'h0456);
    op_q[1].push_back(15'h0789); op_q[1].push_back(15'h0ABC);
    push_iss(0, 15'h0123); push_iss(1, 15'h0789); push_iss(1, 15'h0ABC);
    push_rsp(0, 1'b0, dp_fn(15'h0123));
    push_rsp(1, 1'b0, dp_fn(15'h0789)); push_rsp(1, 1'b0, dp_fn(15'h0ABC));
    hold = 1'b0;
    repeat (30) @(negedge clk);
    check("t4 issues done", 64'(exp_iss.size()), 64'd0);
    check("t4 rsp1 done", 64'(exp_rsp[1].size()), 64'd0);
    check("t4 slot0 held", 64'(bus.rsp_valid[0]), 64'd1);
    check("t4 slot0 data", 64'(bus.rsp_data[RW-1:0]), 64'(dp_fn(15'h0123)));
    check("t4 req0 blocked", 64'({bus.req_valid[0], bus.req_ready[0]}), 64'b10);
    push_iss(0, 15'h0456); push_rsp(0, 1'b0, dp_fn(15'h0456));
    @(posedge clk); #1;
    bus.rsp_ready = '1;
    wait_idle("t4");

    // 5: reset with two ops in flight; late results raise drop_err only.
    do_reset();
    op_q[0].push_back(15'h0111); op_q[1].push_back(15'h0222);
    push_iss(0, 15'h0111); push_iss(1, 15'h0222);
    hold = 1'b0;
    for (int c = 0; c < 20 && exp_iss.size() != 0; c++) @(negedge clk);
    check("t5 issued", 64'(exp_iss.size()), 64'd0);
    hold = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("t5 rst dp_valid", 64'(bus.dp_valid), 64'd0);
    check("t5 rst dp_tag", 64'({bus.dp_tag, bus.dp_data}), 64'd0);
    check("t5 rst req_ready", 64'(bus.req_ready), 64'd0);
    check("t5 rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    check("t5 drop_err", 64'(bus.drop_err), 64'd1);
    check("t5 no rsp", 64'(bus.rsp_valid), 64'd0);

    // 6: orphan tag 3 without reset; drop_err is sticky.
    do_reset();
    check("t6 drop_err clear", 64'(bus.drop_err), 64'd0);
    inj_tag = 2'd3;
    inj_pending = 1'b1;
    repeat (2) @(negedge clk);
    check("t6 drop_err set", 64'(bus.drop_err), 64'd1);
    check("t6 no rsp", 64'(bus.rsp_valid), 64'd0);
    op_q[3].push_back(15'h0333);
    push_iss(3, 15'h0333); push_rsp(3, 1'b0, dp_fn(15'h0333));
    hold = 1'b0;
    wait_idle("t6");
    check("t6 drop_err sticky", 64'(bus.drop_err), 64'd1);

    repeat (3) @(negedge clk);
    check("final issue queue", 64'(exp_iss.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
